// File: rtl/shifter_pkg.sv
// shifter_pkg: operation encodings and the log2 helper shared by the barrel shifter.
package shifter_pkg;
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one combinational log-shifter stage moving data by DIST when enabled.
module shift_stage import shifter_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic             en,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] shifted;
    // SRA replicates the current MSB, which every earlier stage preserved as the sign
    always_comb begin
        shifted = op == OP_SLL ? data << DIST :
                  op == OP_SRL ? data >> DIST :
                  op == OP_SRA ? {{DIST{data[WIDTH-1]}}, data[WIDTH-1:DIST]} :
                                 {data[DIST-1:0], data[WIDTH-1:DIST]};
        result  = en ? shifted : data;
    end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log shifter (SLL/SRL/SRA/ROR) with a register every REG_EVERY stages
// and a global valid/ready stall; a result appears L = ceil(S/REG_EVERY) cycles after acceptance.
module pipelined_barrel_shifter import shifter_pkg::*; #(
    parameter  int WIDTH     = 32,
    parameter  int REG_EVERY = 1,
    localparam int S         = clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] B,
    input  logic [S-1:0]     AMT,
    input  logic [1:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Z,
    output logic             OUT_ZERO
);
    logic             en;
    logic [WIDTH-1:0] d [0:S];
    logic             v [0:S];
    logic [1:0]       o [0:S-1];
    logic [S-1:0]     a [0:S-1];
    logic [WIDTH-1:0] c [0:S-1];
    logic             zero_q;

    assign en        = ~v[S] | OUT_READY;
    assign IN_READY  = en;
    assign d[0]      = B;
    assign v[0]      = IN_VALID;
    assign o[0]      = OP;
    assign a[0]      = AMT;
    assign Z         = d[S];
    assign OUT_VALID = v[S];
    assign OUT_ZERO  = zero_q;

    genvar k;
    for (k = 0; k < S; k++) begin : g_stage
        localparam bit R = ((k + 1) % REG_EVERY == 0) || (k == S - 1);
        shift_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
            .data(d[k]), .op(o[k]), .en(a[k][k]), .result(c[k])
        );
        if (R) begin : g_reg
            logic [WIDTH-1:0] rd;
            logic             rv;
            always_ff @(posedge CLK or posedge RST)
                if (RST) begin
                    rd <= '0;
                    rv <= 1'b0;
                end else if (en) begin
                    rd <= c[k];
                    rv <= v[k];
                end
            assign d[k+1] = rd;
            assign v[k+1] = rv;
        end else begin : g_pass
            assign d[k+1] = c[k];
            assign v[k+1] = v[k];
        end
        // op/amount are only carried to stages that still need them
        if (k < S - 1) begin : g_ctl
            if (R) begin : g_reg
                logic [1:0]   ro;
                logic [S-1:0] ra;
                always_ff @(posedge CLK or posedge RST)
                    if (RST) begin
                        ro <= '0;
                        ra <= '0;
                    end else if (en) begin
                        ro <= o[k];
                        ra <= a[k];
                    end
                assign o[k+1] = ro;
                assign a[k+1] = ra;
            end else begin : g_pass
                assign o[k+1] = o[k];
                assign a[k+1] = a[k];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) zero_q <= 1'b0;
        else if (en) zero_q <= v[S-1] && c[S-1] == '0;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: randomized and directed checks of the shifter against an arithmetic model.
module tb_pipelined_barrel_shifter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [31:0] b, z;
    logic [4:0]  amt;
    logic [1:0]  op;

    logic        v8, r8, ov8, or8, oz8;
    logic [7:0]  b8, z8;
    logic [2:0]  amt8;
    logic [1:0]  op8;

    logic        v64, r64, ov64, or64, oz64;
    logic [63:0] b64, z64;
    logic [5:0]  amt64;
    logic [1:0]  op64;

    int checks = 0;
    int errors = 0;

    pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(1)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_READY(in_ready), .B(b), .AMT(amt), .OP(op),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .Z(z), .OUT_ZERO(out_zero)
    );
    pipelined_barrel_shifter #(.WIDTH(8), .REG_EVERY(3)) dut8 (
        .CLK(CLK), .RST(RST), .IN_VALID(v8), .IN_READY(r8), .B(b8), .AMT(amt8), .OP(op8),
        .OUT_VALID(ov8), .OUT_READY(or8), .Z(z8), .OUT_ZERO(oz8)
    );
    pipelined_barrel_shifter #(.WIDTH(64), .REG_EVERY(2)) dut64 (
        .CLK(CLK), .RST(RST), .IN_VALID(v64), .IN_READY(r64), .B(b64), .AMT(amt64), .OP(op64),
        .OUT_VALID(ov64), .OUT_READY(or64), .Z(z64), .OUT_ZERO(oz64)
    );

    function automatic logic [31:0] model(input logic [31:0] x, input int n, input logic [1:0] f);
        logic signed [31:0] sx;
        sx = x;
        case (f)
            2'b00:   return x << n;
            2'b01:   return x >> n;
            2'b10:   return 32'(sx >>> n);
            default: return n == 0 ? x : (x >> n) | (x << (32 - n));
        endcase
    endfunction

    // drives one transaction into the idle 32-bit pipe and waits (bounded) for its result
    task automatic run_one(input logic [31:0] xb, input logic [4:0] xa, input logic [1:0] xo,
                           output logic [31:0] rz, output logic rzf, output int lat);
        in_valid = 1'b1; b = xb; amt = xa; op = xo; out_ready = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        rz = z; rzf = out_zero;
        if (!out_valid) lat = -1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        in_valid = 0; b = 0; amt = 0; op = 0; out_ready = 1;
        v8 = 0; b8 = 0; amt8 = 0; op8 = 0; or8 = 1;
        v64 = 0; b64 = 0; amt64 = 0; op64 = 0; or64 = 1;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (z !== 32'h0) begin errors++; $display("FAIL reset_z got %h want 0", z); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", out_zero); end
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] tb_b [10] = '{32'h1, 32'h80000000, 32'h80000000, 32'h80000000, 32'hF1,
                                   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h80000000};
        logic [4:0]  tb_a [10] = '{5'd31, 5'd4, 5'd4, 5'd31, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1};
        logic [1:0]  tb_o [10] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [31:0] tb_z [10] = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'hFFFFFFFF, 32'h1000000F,
                                   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        logic [31:0] rz;
        logic        rzf;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            run_one(tb_b[i], tb_a[i], tb_o[i], rz, rzf, lat);
            checks++; if (lat != 5) begin errors++; $display("FAIL directed%0d_latency got %0d want 5", i, lat); end
            checks++; if (rz !== tb_z[i]) begin errors++; $display("FAIL directed%0d_z got %h want %h", i, rz, tb_z[i]); end
            checks++; if (rzf !== (tb_z[i] == 0)) begin errors++; $display("FAIL directed%0d_zero got %b want %b", i, rzf, tb_z[i] == 0); end
        end
    endtask

    task automatic test_ror_random();
        logic [31:0] xb, rz;
        logic [4:0]  xa;
        logic        rzf;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            xb = $urandom; xa = 5'($urandom_range(0, 31));
            run_one(xb, xa, 2'b11, rz, rzf, lat);
            checks++; if (rz !== model(xb, xa, 2'b11)) begin errors++; $display("FAIL ror%0d_z got %h want %h", i, rz, model(xb, xa, 2'b11)); end
            checks++; if ($countones(rz) != $countones(xb)) begin errors++; $display("FAIL ror%0d_popcount got %0d want %0d", i, $countones(rz), $countones(xb)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expq [$];
        logic [31:0] zs, e;
        logic        acc, con, stall, zfs;
        int          sent = 0, got = 0, cyc = 0;
        in_valid = 1; b = $urandom; amt = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
        while (got < 20 && cyc < 500) begin
            out_ready = ($urandom_range(0, 99) < 55);
            #1;
            checks++; if (in_ready !== !(out_valid && !out_ready)) begin errors++; $display("FAIL stream_in_ready got %b want %b", in_ready, !(out_valid && !out_ready)); end
            acc = in_valid && in_ready; con = out_valid && out_ready; stall = out_valid && !out_ready;
            zs = z; zfs = out_zero;
            if (con) begin
                e = expq.size() > 0 ? expq.pop_front() : 32'hx;
                checks++; if (z !== e) begin errors++; $display("FAIL stream%0d_z got %h want %h", got, z, e); end
                checks++; if (out_zero !== (e == 0)) begin errors++; $display("FAIL stream%0d_zero got %b want %b", got, out_zero, e == 0); end
                got++;
            end
            if (acc) begin
                expq.push_back(model(b, amt, op));
                sent++;
            end
            @(posedge CLK); #1;
            if (stall) begin
                checks++; if (!out_valid || z !== zs || out_zero !== zfs) begin errors++; $display("FAIL stream_stall_hold got %b/%h want 1/%h", out_valid, z, zs); end
            end
            if (acc) begin
                if (sent < 20) begin
                    b = $urandom; amt = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
                end else in_valid = 0;
            end
            cyc++;
        end
        checks++; if (got != 20) begin errors++; $display("FAIL stream_count got %0d want 20", got); end
        out_ready = 1; in_valid = 0;
        repeat (6) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rz;
        logic        rzf;
        int          lat;
        bit          stale = 0;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; b = $urandom | 32'h1; amt = 5'(i); op = 2'b01;
            @(posedge CLK); #1;
        end
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill_valid got %b want 1", out_valid); end
        #2 RST = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
        checks++; if (z !== 32'h0) begin errors++; $display("FAIL mid_reset_z got %h want 0", z); end
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        repeat (8) begin
            @(posedge CLK); #1;
            if (out_valid) stale = 1;
        end
        checks++; if (stale) begin errors++; $display("FAIL mid_stale got valid want none"); end
        run_one(32'h0000F000, 5'd12, 2'b01, rz, rzf, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL mid_post_latency got %0d want 5", lat); end
        checks++; if (rz !== 32'hF) begin errors++; $display("FAIL mid_post_z got %h want 0000000f", rz); end
    endtask

    task automatic test_sweep();
        int lat;
        v8 = 1; b8 = 8'h81; amt8 = 3'd1; op8 = 2'b00; or8 = 1;
        @(posedge CLK); #1;
        v8 = 0;
        checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL w8_valid got %b want 1", ov8); end
        checks++; if (z8 !== 8'h02) begin errors++; $display("FAIL w8_z got %h want 02", z8); end
        v64 = 1; b64 = 64'h1; amt64 = 6'd63; op64 = 2'b11; or64 = 1;
        @(posedge CLK); #1;
        v64 = 0;
        lat = 1;
        while (!ov64 && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL w64_latency got %0d want 3", lat); end
        checks++; if (z64 !== 64'h2) begin errors++; $display("FAIL w64_z got %h want 2", z64); end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ror_random();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
